// File: rtl/add7_seq_frontend.sv
// Streaming front end for the 7-operand adder core: collects a..g serially, launches the core,
// returns its sum with a range-error flag. Optional macro ADD7_TIMEOUT_EN bounds the wait on w_enable.
module add7_seq_frontend #(
  parameter int NARROW_W = 10,
  parameter int WIDE_W   = 13,
  parameter int TIMEOUT  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDE_W-1:0]   in_data,
  output logic [NARROW_W-1:0] init_a,
  output logic [NARROW_W-1:0] init_b,
  output logic [NARROW_W-1:0] init_c,
  output logic [NARROW_W-1:0] init_d,
  output logic [WIDE_W-1:0]   init_e,
  output logic [NARROW_W-1:0] init_f,
  output logic [WIDE_W-1:0]   init_g,
  output logic                r_enable,
  input  logic                w_enable,
  input  logic [WIDE_W-1:0]   result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDE_W-1:0]   out_data,
  output logic                out_err,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  state_t              state_r;
  logic [2:0]          cnt_r;
  logic                err_r;
  logic                first_wait_r;
  logic                r_enable_r;
  logic                out_valid_r;
  logic                out_err_r;
  logic [WIDE_W-1:0]   out_data_r;
  logic [NARROW_W-1:0] init_a_r, init_b_r, init_c_r, init_d_r, init_f_r;
  logic [WIDE_W-1:0]   init_e_r, init_g_r;
  logic                narrow_slot_s;
  logic                hi_nz_s;
  logic                done_s;
  logic                tmo_hit_s;

  assign in_ready  = (state_r == ST_COLLECT);
  assign busy      = (state_r != ST_COLLECT);
  assign r_enable  = r_enable_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;
  assign init_a    = init_a_r;
  assign init_b    = init_b_r;
  assign init_c    = init_c_r;
  assign init_d    = init_d_r;
  assign init_e    = init_e_r;
  assign init_f    = init_f_r;
  assign init_g    = init_g_r;

  // The core's w_enable is still the previous run's level during the first WAIT cycle.
  assign done_s = w_enable & ~first_wait_r;

  // Slot classification and upper-bit range check of the current beat.
  always_comb begin
    hi_nz_s = (in_data[WIDE_W-1:NARROW_W] != '0);
    case (cnt_r)
      3'd4, 3'd6: narrow_slot_s = 1'b0;
      default:    narrow_slot_s = 1'b1;
    endcase
  end

`ifdef ADD7_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  logic [TMO_W-1:0] tmo_r;

  assign tmo_hit_s = (tmo_r == TMO_W'(TIMEOUT - 1));

  // WAIT-cycle counter, zero outside WAIT so it restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_r <= '0;
    end else if (state_r == ST_WAIT) begin
      tmo_r <= tmo_r + TMO_W'(1);
    end else begin
      tmo_r <= '0;
    end
  end
`else
  logic unused_s;
  assign unused_s  = (TIMEOUT != 32'sd0);
  assign tmo_hit_s = 1'b0;
`endif

  // Sequencer: collect, launch, wait for the core, present the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_COLLECT;
      cnt_r        <= 3'd0;
      err_r        <= 1'b0;
      first_wait_r <= 1'b0;
      r_enable_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_err_r    <= 1'b0;
      out_data_r   <= '0;
      init_a_r     <= '0;
      init_b_r     <= '0;
      init_c_r     <= '0;
      init_d_r     <= '0;
      init_e_r     <= '0;
      init_f_r     <= '0;
      init_g_r     <= '0;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (in_valid) begin
            case (cnt_r)
              3'd0:    init_a_r <= in_data[NARROW_W-1:0];
              3'd1:    init_b_r <= in_data[NARROW_W-1:0];
              3'd2:    init_c_r <= in_data[NARROW_W-1:0];
              3'd3:    init_d_r <= in_data[NARROW_W-1:0];
              3'd4:    init_e_r <= in_data;
              3'd5:    init_f_r <= in_data[NARROW_W-1:0];
              3'd6:    init_g_r <= in_data;
              default: init_a_r <= init_a_r;
            endcase
            err_r <= err_r | (narrow_slot_s & hi_nz_s);
            if (cnt_r == 3'd6) begin
              cnt_r      <= 3'd0;
              r_enable_r <= 1'b1;
              state_r    <= ST_LAUNCH;
            end else begin
              cnt_r <= cnt_r + 3'd1;
            end
          end
        end
        ST_LAUNCH: begin
          r_enable_r   <= 1'b0;
          first_wait_r <= 1'b1;
          state_r      <= ST_WAIT;
        end
        ST_WAIT: begin
          first_wait_r <= 1'b0;
          if (done_s) begin
            out_data_r  <= result;
            out_err_r   <= err_r;
            out_valid_r <= 1'b1;
            state_r     <= ST_OUTPUT;
          end else if (tmo_hit_s) begin
            out_data_r  <= '0;
            out_err_r   <= 1'b1;
            out_valid_r <= 1'b1;
            state_r     <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            err_r       <= 1'b0;
            state_r     <= ST_COLLECT;
          end
        end
        default: begin
          state_r <= ST_COLLECT;
          cnt_r   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add7_seq_frontend.sv
// Scoreboard bench for add7_seq_frontend with a behavioural model of the adder core.
`timescale 1ns/1ps
module tb_add7_seq_frontend;
  localparam int NW = 10;
  localparam int WW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          w_enable = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic [WW-1:0] result = '0;
  logic          in_ready, r_enable, out_valid, out_err, busy;
  logic [WW-1:0] out_data, init_e, init_g;
  logic [NW-1:0] init_a, init_b, init_c, init_d, init_f;

  int            checks = 0;
  int            fails = 0;
  int            renable_cnt = 0;
  int            lat = 0;
  logic          core_mute = 1'b0;
  logic [WW:0]   sb[$];

  always #5 clk = ~clk;

  add7_seq_frontend #(.NARROW_W(NW), .WIDE_W(WW), .TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .init_a(init_a), .init_b(init_b), .init_c(init_c), .init_d(init_d),
    .init_e(init_e), .init_f(init_f), .init_g(init_g),
    .r_enable(r_enable), .w_enable(w_enable), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy)
  );

  // Core model: w_enable drops one cycle after the load, rises 8 cycles after it.
  always @(posedge clk) begin
    if (r_enable) begin
      lat <= 8;
      renable_cnt <= renable_cnt + 1;
    end else if (lat != 0) begin
      lat <= lat - 1;
      if (lat == 8) w_enable <= 1'b0;
      if (lat == 1 && !core_mute) begin
        w_enable <= 1'b1;
        result   <= WW'(init_a) + WW'(init_b) + WW'(init_c) + WW'(init_d)
                  + init_e + WW'(init_f) + init_g;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected {err, data}.
  always @(negedge clk) begin
    logic [WW:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", out_data, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e[WW-1:0]);
        chk("out_err", out_err, e[WW]);
      end
    end
  end

  task automatic send(input logic [WW-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_txn(input logic [WW-1:0] a, b, c, d, e, f, g,
                          input logic [WW-1:0] exp_d, input logic exp_e, input logic push);
    if (push) sb.push_back({exp_e, exp_d});
    send(a); send(b); send(c); send(d); send(e); send(f); send(g);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_rise", out_valid, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", (sb.size() == 0 && !busy), 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_r_enable", r_enable, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_init_a", init_a, 0);
    chk("rst_init_g", init_g, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst_n = 1'b1;

    // Basic sum with in_ready low from LAUNCH until after the handshake.
    send_txn(1, 2, 3, 4, 5, 6, 7, 28, 1'b0, 1'b1);
    chk("launch_in_ready", in_ready, 0);
    wait_valid();
    chk("valid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
    chk("renable_1", renable_cnt, 1);
    wait_done();

    // Wrap modulo 2^13: 5*1023 + 2*8191 = 21497 -> 5113.
    send_txn(1023, 1023, 1023, 1023, 8191, 1023, 8191, 5113, 1'b0, 1'b1);
    wait_done();
    chk("renable_2", renable_cnt, 2);

    // Out-of-range narrow beat, then a clean transaction clears the error.
    send_txn(0, 13'h400, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    wait_valid();
    chk("init_b_trunc", init_b, 0);
    wait_done();
    send_txn(1, 2, 3, 4, 5, 6, 7, 28, 1'b0, 1'b1);
    wait_done();

    // Backpressure: output held stable, no relaunch.
    out_ready = 1'b0;
    send_txn(100, 0, 0, 0, 200, 0, 300, 600, 1'b0, 1'b1);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 600);
      chk("bp_out_err", out_err, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("renable_5", renable_cnt, 5);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    wait_done();

    // Reset after four beats discards the partial set.
    send(99); send(99); send(99); send(99);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_txn(10, 20, 30, 40, 50, 60, 70, 280, 1'b0, 1'b1);
    wait_done();
    chk("renable_6", renable_cnt, 6);

    // Reset during WAIT; the late w_enable must be ignored.
    send_txn(1, 2, 3, 4, 5, 6, 7, 0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("wait_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("late_w_enable_ignored", n, 0);
    chk("renable_7", renable_cnt, 7);

    // Core never answers.
    core_mute = 1'b1;
`ifdef ADD7_TIMEOUT_EN
    send_txn(1, 2, 3, 4, 5, 6, 7, 0, 1'b1, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_latency", n, 33);
    wait_done();
`else
    send_txn(1, 2, 3, 4, 5, 6, 7, 0, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("no_timeout_valid", n, 0);
    chk("no_timeout_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif
    core_mute = 1'b0;
    chk("renable_8", renable_cnt, 8);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
